// File: rtl/ts_packet_arbiter.sv
// ============================================================================
// Module   : ts_packet_arbiter
// Purpose  : Packet-atomic round-robin arbiter feeding one TS FIFO write port.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ts_packet_arbiter #(
  parameter int NUM_SRC = 2,
  parameter int PKT_LEN = 188,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [8*NUM_SRC-1:0] src_data_i,
  input  logic [NUM_SRC-1:0]   src_valid_i,
  input  logic [NUM_SRC-1:0]   src_sync_i,
  output logic [NUM_SRC-1:0]   src_ready_o,
  input  logic [NUM_SRC-1:0]   src_enable_i,
  input  logic                 fifo_full_i,
  output logic                 fifo_w_en_o,
  output logic [9:0]           fifo_data_o,
  output logic [NUM_SRC-1:0]   grant_o,
  output logic [CNT_W-1:0]     pkt_count_o,
  output logic [CNT_W-1:0]     err_count_o
);

  localparam int IDX_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int BCNT_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [BCNT_W-1:0] C_LAST_BYTE = BCNT_W'(PKT_LEN - 1);
  localparam logic [IDX_W-1:0]  C_LAST_INIT = IDX_W'(NUM_SRC - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   g_q, g_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [BCNT_W-1:0]  bcnt_q, bcnt_d;
  logic [CNT_W-1:0]   pkt_q, pkt_d;
  logic [CNT_W-1:0]   err_q, err_d;

  logic [7:0]         w_bytes [NUM_SRC];
  logic [NUM_SRC-1:0] w_cand;
  logic [NUM_SRC-1:0] w_drop;
  logic               w_found;
  logic [IDX_W-1:0]   w_win;
  logic               w_xfer;

  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_unpack
      assign w_bytes[gi] = src_data_i[8*gi +: 8];
    end
  endgenerate

  assign w_cand = src_enable_i & src_valid_i & src_sync_i;
  assign w_drop = src_valid_i & ~src_sync_i;
  assign w_xfer = (state_q == XFER) & src_valid_i[g_q] & ~fifo_full_i;

  // Offsets are scanned from farthest to nearest so the source right after
  // the last-served one is written last and therefore wins.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int k = NUM_SRC; k >= 1; k--) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (w_cand[i] && (((int'(last_q) + k) % NUM_SRC) == i)) begin
          w_found = 1'b1;
          w_win   = IDX_W'(i);
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    g_d         = g_q;
    last_d      = last_q;
    bcnt_d      = bcnt_q;
    pkt_d       = pkt_q;
    err_d       = err_q;
    src_ready_o = '0;
    grant_o     = '0;
    fifo_w_en_o = w_xfer;
    fifo_data_o = {w_bytes[g_q], 1'b1, src_sync_i[g_q]};

    case (state_q)
      IDLE: begin
        src_ready_o = w_drop;
        if (|w_drop && (err_q != '1)) begin
          err_d = err_q + 1'b1;
        end
        if (w_found) begin
          g_d     = w_win;
          bcnt_d  = '0;
          state_d = XFER;
        end
      end
      XFER: begin
        grant_o[g_q]     = 1'b1;
        src_ready_o[g_q] = ~fifo_full_i;
        if (w_xfer) begin
          bcnt_d = bcnt_q + 1'b1;
          // A stray sync inside a packet is forwarded as data but still counted.
          if (src_sync_i[g_q] && (bcnt_q != '0) && (err_q != '1)) begin
            err_d = err_q + 1'b1;
          end
          if (bcnt_q == C_LAST_BYTE) begin
            pkt_d   = pkt_q + 1'b1;
            last_d  = g_q;
            bcnt_d  = '0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      g_q     <= '0;
      last_q  <= C_LAST_INIT;
      bcnt_q  <= '0;
      pkt_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      last_q  <= last_d;
      bcnt_q  <= bcnt_d;
      pkt_q   <= pkt_d;
      err_q   <= err_d;
    end
  end

  assign pkt_count_o = pkt_q;
  assign err_count_o = err_q;

endmodule

`default_nettype wire

// File: tb/tb_ts_packet_arbiter.sv
// ============================================================================
// Module   : tb_ts_packet_arbiter
// Purpose  : Randomized self-checking bench for ts_packet_arbiter.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ts_packet_arbiter;

  localparam int NSRC = 2;
  localparam int PLEN = 188;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [8*NSRC-1:0] src_data;
  logic [NSRC-1:0]   src_valid, src_sync, src_ready, src_enable, grant;
  logic              fifo_full, fifo_w_en;
  logic [9:0]        fifo_data;
  logic [CW-1:0]     pkt_count, err_count;

  ts_packet_arbiter #(.NUM_SRC(NSRC), .PKT_LEN(PLEN), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .src_data_i  (src_data),
    .src_valid_i (src_valid),
    .src_sync_i  (src_sync),
    .src_ready_o (src_ready),
    .src_enable_i(src_enable),
    .fifo_full_i (fifo_full),
    .fifo_w_en_o (fifo_w_en),
    .fifo_data_o (fifo_data),
    .grant_o     (grant),
    .pkt_count_o (pkt_count),
    .err_count_o (err_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Source streams: {sync,data} bytes to present, and the FIFO words each
  // source's packet bytes must eventually produce, in order.
  logic [8:0]      q       [NSRC][$];
  logic [9:0]      exp_out [NSRC][$];
  logic [NSRC-1:0] pres = '0;
  int              vprob = 100;
  int              full_mode = 0;
  bit              rand_gen = 1'b0;
  int              cyc = 0;

  task automatic push_pkt(int s, int junk, int extra_at, bit rnd);
    logic [7:0] d;
    logic       sy;
    for (int j = 0; j < junk; j++) q[s].push_back({1'b0, 8'($urandom_range(255))});
    for (int b = 0; b < PLEN; b++) begin
      if (b == 0) begin
        d  = 8'h47;
        sy = 1'b1;
      end else begin
        d  = rnd ? 8'($urandom_range(255)) : 8'(b + 16 * s);
        sy = (b == extra_at) || (rnd && ($urandom_range(199) == 0));
        if (b == extra_at) d = 8'h47;
      end
      q[s].push_back({sy, d});
      exp_out[s].push_back({d, 1'b1, sy});
    end
  endtask

  task automatic step();
    logic [NSRC-1:0] acc;
    @(negedge clk);
    acc = src_valid & src_ready;
    @(posedge clk);
    #1;
    cyc++;
    for (int s = 0; s < NSRC; s++) begin
      if (acc[s] && pres[s]) begin
        void'(q[s].pop_front());
        pres[s] = 1'b0;
      end
      if (rand_gen && (q[s].size() == 0))
        push_pkt(s, ($urandom_range(1) == 1) ? int'($urandom_range(3, 1)) : 0, -1, 1'b1);
      if (!pres[s] && (q[s].size() > 0) && (int'($urandom_range(99)) < vprob)) pres[s] = 1'b1;
      src_valid[s]       = pres[s];
      src_sync[s]        = pres[s] ? q[s][0][8] : 1'b0;
      src_data[8*s +: 8] = pres[s] ? q[s][0][7:0] : 8'h00;
    end
    case (full_mode)
      1:       fifo_full = ((cyc % 10) < 3);
      2:       fifo_full = ($urandom_range(9) == 0);
      default: fifo_full = 1'b0;
    endcase
  endtask

  task automatic do_reset(int cycles);
    rst_n = 1'b0;
    for (int s = 0; s < NSRC; s++) begin
      q[s].delete();
      exp_out[s].delete();
    end
    pres      = '0;
    src_valid = '0;
    src_sync  = '0;
    src_data  = '0;
    fifo_full = 1'b0;
    repeat (cycles) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic run_until_pkt(int target, int budget, string name);
    int c = 0;
    while ((int'(pkt_count) != target) && (c < budget)) begin
      step();
      c++;
    end
    chk(name, int'(pkt_count), target);
  endtask

  function automatic int pick(logic [NSRC-1:0] cand, int last);
    for (int k = 1; k <= NSRC; k++)
      if (cand[(last + k) % NSRC]) return (last + k) % NSRC;
    return -1;
  endfunction

  // Reference model: owner index (-1 = idle), bytes forwarded, counters.
  int              m_owner = -1, m_cnt = 0, m_last = NSRC - 1, m_pkt = 0, m_err = 0;
  int              n_wr = 0, n_sw = 0, n_g0 = 0, n_wfull = 0;
  logic [NSRC-1:0] first_g = '0;

  always @(negedge clk) begin
    logic [NSRC-1:0] e_ready, e_grant;
    logic            e_wen;
    logic [9:0]      e_data, sb;
    int              win;
    if (!rst_n) begin
      m_owner = -1; m_cnt = 0; m_last = NSRC - 1; m_pkt = 0; m_err = 0;
    end else begin
      e_grant = (m_owner < 0) ? '0 : (NSRC'(1) << m_owner);
      if (m_owner < 0) begin
        e_ready = src_valid & ~src_sync;
        e_wen   = 1'b0;
        e_data  = '0;
      end else begin
        e_ready = fifo_full ? '0 : e_grant;
        e_wen   = src_valid[m_owner] & ~fifo_full;
        e_data  = {src_data[8*m_owner +: 8], 1'b1, src_sync[m_owner]};
      end
      chk("grant", int'(grant), int'(e_grant));
      chk("src_ready", int'(src_ready), int'(e_ready));
      chk("fifo_w_en", int'(fifo_w_en), int'(e_wen));
      chk("pkt_count", int'(pkt_count), m_pkt);
      chk("err_count", int'(err_count), m_err);
      if (e_wen && fifo_w_en) chk("fifo_data", int'(fifo_data), int'(e_data));
      if (fifo_w_en && (m_owner >= 0)) begin
        if (exp_out[m_owner].size() == 0) begin
          chk("sb_underflow", 1, 0);
        end else begin
          sb = exp_out[m_owner].pop_front();
          chk("sb_order", int'(fifo_data), int'(sb));
        end
      end
      if (fifo_w_en) begin
        n_wr++;
        if (fifo_data == 10'h11F) n_sw++;
        if (first_g == '0) first_g = grant;
        if (fifo_full) n_wfull++;
      end
      if (grant == 2'b01) n_g0++;

      if (m_owner < 0) begin
        if (|(src_valid & ~src_sync)) m_err = (m_err == CMAX) ? CMAX : m_err + 1;
        win = pick(src_enable & src_valid & src_sync, m_last);
        if (win >= 0) begin
          m_owner = win;
          m_cnt   = 0;
        end
      end else if (e_wen) begin
        if (src_sync[m_owner] && (m_cnt != 0)) m_err = (m_err == CMAX) ? CMAX : m_err + 1;
        m_cnt++;
        if (m_cnt == PLEN) begin
          m_pkt   = (m_pkt + 1) % (CMAX + 1);
          m_last  = m_owner;
          m_owner = -1;
        end
      end
    end
  end

  initial begin
    src_enable = '1;
    src_valid  = '0;
    src_sync   = '0;
    src_data   = '0;
    fifo_full  = 1'b0;
    do_reset(3);

    // Idle after reset
    for (int c = 0; c < 20; c++) step();
    chk("idle_grant", int'(grant), 0);
    chk("idle_pkt", int'(pkt_count), 0);
    chk("idle_err", int'(err_count), 0);
    chk("idle_writes", n_wr, 0);

    // Both sources sync together: src0 first, then src1
    n_wr = 0; n_sw = 0; first_g = '0;
    push_pkt(0, 0, -1, 1'b0);
    push_pkt(1, 0, -1, 1'b0);
    run_until_pkt(2, 800, "two_src_pkt");
    chk("two_src_writes", n_wr, 2 * PLEN);
    chk("two_src_syncwords", n_sw, 2);
    chk("two_src_first_grant", int'(first_g), 1);

    // FIFO full 3 of every 10 cycles
    n_wr = 0; n_wfull = 0; full_mode = 1;
    push_pkt(1, 0, -1, 1'b0);
    run_until_pkt(3, 800, "full_pkt");
    full_mode = 0;
    chk("full_writes", n_wr, PLEN);
    chk("full_write_while_full", n_wfull, 0);

    // Five misaligned bytes ahead of a packet
    n_wr = 0;
    push_pkt(0, 5, -1, 1'b0);
    run_until_pkt(4, 800, "junk_pkt");
    chk("junk_err", int'(err_count), 5);
    chk("junk_writes", n_wr, PLEN);

    // Extra sync at byte 100
    n_wr = 0;
    push_pkt(0, 0, 100, 1'b0);
    run_until_pkt(5, 800, "extra_sync_pkt");
    chk("extra_sync_err", int'(err_count), 6);
    chk("extra_sync_writes", n_wr, PLEN);

    // Only src1 enabled, then reset in the middle of a packet
    src_enable = 2'b10;
    n_wr = 0; n_g0 = 0;
    push_pkt(0, 0, -1, 1'b0);
    push_pkt(1, 0, -1, 1'b0);
    push_pkt(1, 0, -1, 1'b0);
    run_until_pkt(7, 1000, "mask_pkt");
    chk("mask_src0_grants", n_g0, 0);
    chk("mask_writes", n_wr, 2 * PLEN);
    push_pkt(1, 0, -1, 1'b0);
    n_wr = 0;
    for (int c = 0; (c < 400) && (n_wr < 50); c++) step();
    chk("reset_at_byte50", n_wr, 50);
    chk("pre_reset_grant", int'(grant), 2);
    rst_n = 1'b0;
    #1;
    chk("async_reset_grant", int'(grant), 0);
    chk("async_reset_pkt", int'(pkt_count), 0);
    chk("async_reset_err", int'(err_count), 0);
    do_reset(2);

    // Randomized traffic: gaps, full, junk, stray syncs, mask changes
    rand_gen = 1'b1;
    for (int blk = 0; blk < 12; blk++) begin
      vprob      = int'($urandom_range(100, 60));
      full_mode  = ($urandom_range(1) == 1) ? 2 : 0;
      src_enable = NSRC'($urandom_range(3, 1));
      for (int c = 0; c < 500; c++) step();
    end
    rand_gen  = 1'b0;
    full_mode = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
